// File: rtl/mem_stage_unit_206.sv
// Memory-access pipeline stage: data RAM with word/byte stores and word/byte loads,
// branch/jump redirect resolution, forwarding taps and the Mem/Wr pipeline register.
module mem_stage_unit_206 #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_Mem,
  input  logic [31:0] ALU_ans_Mem,
  input  logic [31:0] busB_Mem,
  input  logic [31:0] B_Addr_Mem,
  input  logic [31:0] J_Addr_Mem,
  input  logic [31:0] PC_Addr_Mem,
  input  logic [4:0]  Reg_Target_Mem,
  input  logic        ZF_Mem,
  input  logic        Branch_Mem,
  input  logic        Jump_Mem,
  input  logic        Rtype_J_Mem,
  input  logic        Jal_Mem,
  input  logic        Rtype_L_Mem,
  input  logic        MemToReg_Mem,
  input  logic        RegWr_Mem,
  input  logic        MemWr_Mem,
  input  logic        WrByte_Mem,
  input  logic [1:0]  LoadByte_Mem,
  output logic [31:0] Ex_Mem_ByPassing,
  output logic        Redirect_Mem,
  output logic [31:0] Target_PC_Mem,
  output logic [31:0] busW_Wr,
  output logic [4:0]  Reg_Target_Wr,
  output logic        RegWr_Wr,
  output logic [31:0] Mem_Wr_ByPassing
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       ram_q [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              link;
  logic              store_en;

  // Mem/Wr pipeline register fields
  logic        regwr_d, regwr_q;
  logic [4:0]  rt_d, rt_q;
  logic        link_d, link_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] alu_d, alu_q;
  logic        m2r_d, m2r_q;
  logic [1:0]  lb_d, lb_q;
  logic [1:0]  lane_d, lane_q;
  logic [31:0] rdata_q;
  logic [7:0]  lane_byte;
  logic [31:0] busw;

  assign word_idx = ALU_ans_Mem[ADDR_W+1:2];
  assign lane     = ALU_ans_Mem[1:0];
  assign link     = Jal_Mem | Rtype_L_Mem;
  assign store_en = MemWr_Mem & ~Stall_Mem & ~rst;

  always_ff @(posedge clk) begin
    if (store_en) begin
      if (WrByte_Mem) ram_q[word_idx][{lane, 3'b000} +: 8] <= busB_Mem[7:0];
      else            ram_q[word_idx] <= busB_Mem;
    end
  end

  assign Ex_Mem_ByPassing = link ? PC_Addr_Mem : ALU_ans_Mem;
  assign Redirect_Mem     = ~Stall_Mem & (Jump_Mem | Rtype_J_Mem | (Branch_Mem & ZF_Mem));

  always_comb begin
    Target_PC_Mem = 32'd0;
    if (Rtype_J_Mem)     Target_PC_Mem = ALU_ans_Mem;
    else if (Jump_Mem)   Target_PC_Mem = J_Addr_Mem;
    else if (Branch_Mem) Target_PC_Mem = B_Addr_Mem;
  end

  always_comb begin
    regwr_d = RegWr_Mem;
    rt_d    = Jal_Mem ? 5'd31 : Reg_Target_Mem;
    link_d  = link;
    pc_d    = PC_Addr_Mem;
    alu_d   = ALU_ans_Mem;
    m2r_d   = MemToReg_Mem;
    lb_d    = LoadByte_Mem;
    lane_d  = lane;
  end

  // Reset wins over stall; the RAM read word is captured alongside the control fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwr_q <= 1'b0;
      rt_q    <= 5'd0;
      link_q  <= 1'b0;
      pc_q    <= 32'd0;
      alu_q   <= 32'd0;
      m2r_q   <= 1'b0;
      lb_q    <= 2'd0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else if (!Stall_Mem) begin
      regwr_q <= regwr_d;
      rt_q    <= rt_d;
      link_q  <= link_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      m2r_q   <= m2r_d;
      lb_q    <= lb_d;
      lane_q  <= lane_d;
      rdata_q <= ram_q[word_idx];
    end
  end

  assign lane_byte = rdata_q[{lane_q, 3'b000} +: 8];

  always_comb begin
    busw = alu_q;
    if (m2r_q) begin
      case (lb_q)
        2'b01:   busw = {{24{lane_byte[7]}}, lane_byte};
        2'b10:   busw = {24'd0, lane_byte};
        default: busw = rdata_q;
      endcase
    end else if (link_q) begin
      busw = pc_q;
    end
  end

  assign busW_Wr          = busw;
  assign Mem_Wr_ByPassing = busw;
  assign Reg_Target_Wr    = rt_q;
  assign RegWr_Wr         = regwr_q;
endmodule

// File: tb/tb_mem_stage_unit_206.sv
// Bench for mem_stage_unit_206: reset, byte/word memory, redirect/link table, stall
// sequences and randomized traffic against a byte-addressed reference memory.
module tb_mem_stage_unit_206;
  localparam int ADDR_W = 10;
  localparam int BYTES  = 4 << ADDR_W;

  typedef struct {
    logic [31:0] alu, busb, baddr, jaddr, pc;
    logic [4:0]  rt;
    logic        zf, br, jmp, rj, jal, rl, m2r, rw, mw, wb;
    logic [1:0]  lb;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] tap;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, Stall_Mem;
  logic [31:0] ALU_ans_Mem, busB_Mem, B_Addr_Mem, J_Addr_Mem, PC_Addr_Mem;
  logic [4:0]  Reg_Target_Mem;
  logic        ZF_Mem, Branch_Mem, Jump_Mem, Rtype_J_Mem, Jal_Mem, Rtype_L_Mem;
  logic        MemToReg_Mem, RegWr_Mem, MemWr_Mem, WrByte_Mem;
  logic [1:0]  LoadByte_Mem;
  logic [31:0] Ex_Mem_ByPassing, Target_PC_Mem, busW_Wr, Mem_Wr_ByPassing;
  logic        Redirect_Mem, RegWr_Wr;
  logic [4:0]  Reg_Target_Wr;

  mem_stage_unit_206 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .Stall_Mem(Stall_Mem),
    .ALU_ans_Mem(ALU_ans_Mem), .busB_Mem(busB_Mem), .B_Addr_Mem(B_Addr_Mem),
    .J_Addr_Mem(J_Addr_Mem), .PC_Addr_Mem(PC_Addr_Mem), .Reg_Target_Mem(Reg_Target_Mem),
    .ZF_Mem(ZF_Mem), .Branch_Mem(Branch_Mem), .Jump_Mem(Jump_Mem), .Rtype_J_Mem(Rtype_J_Mem),
    .Jal_Mem(Jal_Mem), .Rtype_L_Mem(Rtype_L_Mem), .MemToReg_Mem(MemToReg_Mem),
    .RegWr_Mem(RegWr_Mem), .MemWr_Mem(MemWr_Mem), .WrByte_Mem(WrByte_Mem),
    .LoadByte_Mem(LoadByte_Mem), .Ex_Mem_ByPassing(Ex_Mem_ByPassing),
    .Redirect_Mem(Redirect_Mem), .Target_PC_Mem(Target_PC_Mem), .busW_Wr(busW_Wr),
    .Reg_Target_Wr(Reg_Target_Wr), .RegWr_Wr(RegWr_Wr), .Mem_Wr_ByPassing(Mem_Wr_ByPassing)
  );

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [BYTES];
  logic [31:0] e_busw;
  logic [4:0]  e_rt;
  logic        e_rw;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int baddr_of(logic [31:0] a);
    return int'(a[ADDR_W+1:0]);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic byte_wr);
    int base;
    if (byte_wr) mem_m[baddr_of(a)] = d[7:0];
    else begin
      base = baddr_of(a) & ~3;
      for (int k = 0; k < 4; k++) mem_m[base + k] = d[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] fmt);
    int base = baddr_of(a) & ~3;
    logic [7:0] b = mem_m[baddr_of(a)];
    logic [31:0] w = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    if (fmt == 2'b01) return (b >= 8'h80) ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
    if (fmt == 2'b10) return 32'(b);
    return w;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t x;
    x = '{alu: 32'd0, busb: 32'd0, baddr: 32'd0, jaddr: 32'd0, pc: 32'd0, rt: 5'd0,
          zf: 1'b0, br: 1'b0, jmp: 1'b0, rj: 1'b0, jal: 1'b0, rl: 1'b0, m2r: 1'b0,
          rw: 1'b0, mw: 1'b0, wb: 1'b0, lb: 2'd0};
    return x;
  endfunction

  function automatic instr_t mk_store(logic [31:0] a, logic [31:0] d, logic byte_wr);
    instr_t x = nop();
    x.alu = a; x.busb = d; x.mw = 1'b1; x.wb = byte_wr;
    return x;
  endfunction

  function automatic instr_t mk_load(logic [31:0] a, logic [1:0] fmt, logic [4:0] rt);
    instr_t x = nop();
    x.alu = a; x.lb = fmt; x.m2r = 1'b1; x.rw = 1'b1; x.rt = rt;
    return x;
  endfunction

  function automatic instr_t mk_ctl(logic br, logic zf, logic jmp, logic rj, logic jal, logic rl,
                                    logic [31:0] alu, logic [31:0] baddr, logic [31:0] jaddr,
                                    logic [31:0] pc);
    instr_t x = nop();
    x.br = br; x.zf = zf; x.jmp = jmp; x.rj = rj; x.jal = jal; x.rl = rl;
    x.alu = alu; x.baddr = baddr; x.jaddr = jaddr; x.pc = pc; x.rw = 1'b1; x.rt = 5'd5;
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input instr_t x);
    ALU_ans_Mem = x.alu; busB_Mem = x.busb; B_Addr_Mem = x.baddr; J_Addr_Mem = x.jaddr;
    PC_Addr_Mem = x.pc; Reg_Target_Mem = x.rt; ZF_Mem = x.zf; Branch_Mem = x.br;
    Jump_Mem = x.jmp; Rtype_J_Mem = x.rj; Jal_Mem = x.jal; Rtype_L_Mem = x.rl;
    MemToReg_Mem = x.m2r; RegWr_Mem = x.rw; MemWr_Mem = x.mw; WrByte_Mem = x.wb;
    LoadByte_Mem = x.lb;
  endtask

  task automatic check_wr(input string tag);
    check({tag, ".busW_Wr"}, busW_Wr, e_busw);
    check({tag, ".Mem_Wr_ByPassing"}, Mem_Wr_ByPassing, e_busw);
    check({tag, ".Reg_Target_Wr"}, 32'(Reg_Target_Wr), 32'(e_rt));
    check({tag, ".RegWr_Wr"}, 32'(RegWr_Wr), 32'(e_rw));
  endtask

  // One Mem-stage cycle: inputs driven just after a rising edge, combinational outputs
  // checked 1 ns later, write-back outputs checked 1 ns after the following edge.
  task automatic run(input instr_t x, input logic stall);
    logic        link;
    logic [31:0] tgt;
    apply(x);
    rst = 1'b0;
    Stall_Mem = stall;
    #1;
    link = x.jal | x.rl;
    tgt = x.rj ? x.alu : x.jmp ? x.jaddr : x.br ? x.baddr : 32'd0;
    check("redirect", 32'(Redirect_Mem), 32'(!stall && (x.jmp || x.rj || (x.br && x.zf))));
    check("target", Target_PC_Mem, tgt);
    check("ex_tap", Ex_Mem_ByPassing, link ? x.pc : x.alu);
    if (!stall) begin
      e_busw = x.m2r ? model_load(x.alu, x.lb) : link ? x.pc : x.alu;
      e_rt   = x.jal ? 5'd31 : x.rt;
      e_rw   = x.rw;
      if (x.mw) model_store(x.alu, x.busb, x.wb);
    end
    @(posedge clk); #1;
    check_wr("wr");
  endtask

  task automatic rst_cycle(input instr_t x);
    apply(x);
    rst = 1'b1;
    Stall_Mem = 1'b0;
    @(posedge clk); #1;
    e_busw = 32'd0; e_rt = 5'd0; e_rw = 1'b0;
    check_wr("reset");
  endtask

  function automatic instr_t rand_instr();
    instr_t x = nop();
    int kind = $urandom_range(0, 5);
    x.alu = $urandom;
    x.alu[ADDR_W+1:6] = '0;  // words 0..15, upper bits random to exercise wrap
    x.busb = $urandom; x.baddr = $urandom; x.jaddr = $urandom; x.pc = $urandom;
    x.rt = 5'($urandom_range(0, 31)); x.zf = 1'($urandom_range(0, 1));
    x.rw = 1'($urandom_range(0, 1));
    case (kind)
      1: begin x.mw = 1'b1; x.wb = 1'($urandom_range(0, 1)); x.rw = 1'b0; end
      2: begin x.m2r = 1'b1; x.lb = 2'($urandom_range(0, 3)); x.rw = 1'b1; end
      3: x.br = 1'b1;
      4: begin x.jmp = 1'($urandom_range(0, 1)); x.rj = ~x.jmp | 1'($urandom_range(0, 1)); end
      5: begin x.jal = 1'($urandom_range(0, 1)); x.rl = ~x.jal; x.rj = x.rl;
               x.jmp = x.jal; x.rw = 1'b1; end
      default: ;
    endcase
    return x;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  vec_t   vecs[8];
  instr_t s, x;

  initial begin
    rst = 1'b1; Stall_Mem = 1'b0;
    apply(nop());
    e_busw = 32'd0; e_rt = 5'd0; e_rw = 1'b0;
    @(posedge clk); #1;

    // Reset with RegWr asserted for two cycles
    x = nop(); x.rw = 1'b1; x.rt = 5'd7; x.alu = 32'h1234;
    rst_cycle(x);
    rst_cycle(x);

    // Reset suppresses a concurrent store to 0x10
    run(mk_store(32'h10, 32'hCAFE_F00D, 1'b0), 1'b0);
    rst_cycle(mk_store(32'h10, 32'h1234_5678, 1'b0));
    rst_cycle(mk_store(32'h10, 32'h1234_5678, 1'b0));
    run(mk_load(32'h10, 2'b00, 5'd2), 1'b0);
    check("reset_store_suppressed", busW_Wr, 32'hCAFE_F00D);

    // Byte store / load formats
    run(mk_store(32'h20, 32'h1122_3344, 1'b0), 1'b0);
    run(mk_store(32'h22, 32'h0000_00F0, 1'b1), 1'b0);
    run(mk_load(32'h20, 2'b00, 5'd3), 1'b0);
    check("load_word", busW_Wr, 32'h11F0_3344);
    run(mk_load(32'h22, 2'b01, 5'd3), 1'b0);
    check("load_sbyte", busW_Wr, 32'hFFFF_FFF0);
    run(mk_load(32'h22, 2'b10, 5'd3), 1'b0);
    check("load_ubyte", busW_Wr, 32'h0000_00F0);
    run(mk_load(32'h23, 2'b11, 5'd3), 1'b0);
    check("load_fmt11_word", busW_Wr, 32'h11F0_3344);

    // Back-to-back store then load
    run(mk_store(32'h40, 32'hDEAD_BEEF, 1'b0), 1'b0);
    run(mk_load(32'h40, 2'b00, 5'd4), 1'b0);
    check("store_then_load", busW_Wr, 32'hDEAD_BEEF);

    // Redirect / tap table
    vecs[0] = '{mk_ctl(1, 0, 0, 0, 0, 0, 32'h11, 32'h100, 32'h300, 32'h44), 1'b0, 32'h100, 32'h11};
    vecs[1] = '{mk_ctl(1, 1, 0, 0, 0, 0, 32'h11, 32'h100, 32'h300, 32'h44), 1'b1, 32'h100, 32'h11};
    vecs[2] = '{mk_ctl(0, 0, 1, 1, 0, 0, 32'h200, 32'h100, 32'h300, 32'h44), 1'b1, 32'h200, 32'h200};
    vecs[3] = '{mk_ctl(0, 0, 1, 0, 0, 0, 32'h22, 32'h100, 32'h300, 32'h44), 1'b1, 32'h300, 32'h22};
    vecs[4] = '{mk_ctl(1, 1, 1, 0, 1, 0, 32'h55, 32'h100, 32'h400, 32'h44), 1'b1, 32'h400, 32'h44};
    vecs[5] = '{mk_ctl(0, 0, 0, 1, 0, 1, 32'h600, 32'h100, 32'h300, 32'h48), 1'b1, 32'h600, 32'h48};
    vecs[6] = '{mk_ctl(0, 0, 0, 0, 0, 0, 32'h77, 32'h100, 32'h300, 32'h44), 1'b0, 32'h0, 32'h77};
    vecs[7] = '{mk_ctl(0, 1, 0, 0, 0, 0, 32'h88, 32'h100, 32'h300, 32'h44), 1'b0, 32'h0, 32'h88};
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].in); rst = 1'b0; Stall_Mem = 1'b0;
      #1;
      check($sformatf("vec%0d.redirect", i), 32'(Redirect_Mem), 32'(vecs[i].redir));
      check($sformatf("vec%0d.target", i), Target_PC_Mem, vecs[i].tgt);
      check($sformatf("vec%0d.tap", i), Ex_Mem_ByPassing, vecs[i].tap);
      run(vecs[i].in, 1'b0);
    end

    // Link: jal forces r31 and writes back the link address
    x = nop(); x.jal = 1'b1; x.pc = 32'h44; x.rt = 5'd5; x.rw = 1'b1; x.alu = 32'h99;
    apply(x); #1;
    check("jal_tap", Ex_Mem_ByPassing, 32'h44);
    run(x, 1'b0);
    check("jal_rt", 32'(Reg_Target_Wr), 32'd31);
    check("jal_busw", busW_Wr, 32'h44);

    // Stall: held store + branch commits exactly once on release
    run(mk_store(32'h30, 32'h0101_0101, 1'b0), 1'b0);
    x = nop(); x.alu = 32'h77; x.rt = 5'd3; x.rw = 1'b1;
    run(x, 1'b0);
    s = mk_store(32'h30, 32'hA5A5_A5A5, 1'b0);
    s.br = 1'b1; s.zf = 1'b1; s.baddr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      run(s, 1'b1);
      check("stall_frozen_busw", busW_Wr, 32'h77);
      check("stall_frozen_rt", 32'(Reg_Target_Wr), 32'd3);
    end
    apply(s); Stall_Mem = 1'b0; #1;
    check("stall_release_redirect", 32'(Redirect_Mem), 32'd1);
    run(s, 1'b0);
    run(mk_load(32'h30, 2'b00, 5'd6), 1'b0);
    check("stall_store_committed", busW_Wr, 32'hA5A5_A5A5);

    // A store that stays stalled and is then withdrawn never reaches the RAM
    for (int i = 0; i < 3; i++) run(mk_store(32'h31, 32'h0000_005A, 1'b1), 1'b1);
    run(mk_load(32'h30, 2'b00, 5'd6), 1'b0);
    check("stalled_store_dropped", busW_Wr, 32'hA5A5_A5A5);

    // Randomized traffic over words 0..15 after prefilling them
    for (int w = 0; w < 16; w++) run(mk_store(32'(w * 4), $urandom, 1'b0), 1'b0);
    for (int n = 0; n < 300; n++) begin
      x = rand_instr();
      while ($urandom_range(0, 4) == 0) run(x, 1'b1);
      run(x, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
